// File: rtl/osborne_kbd_matrix.sv
// Osborne 1 keyboard matrix built from hps_io ps2_key events.
// Three-step event pipeline (detect, table lookup, matrix update), a
// combinational column read path, and a held Ctrl+Alt+Del reset request.
module osborne_kbd_matrix #(
  parameter int RST_HOLD = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [7:0]  row_sel_n,
  output logic [7:0]  col_n,
  output logic        key_event,
  output logic        rst_req
);

  localparam int CW = $clog2(RST_HOLD + 1);

  // Modifier role of a code; shared matrix bits are the OR of both keys.
  typedef enum logic [2:0] {
    M_NONE, M_LSH, M_RSH, M_CTLL, M_CTLR, M_ALT, M_DEL
  } mod_e;

  // S0 latch
  logic       strobe_q;
  logic [1:0] vld_pipe_q;   // [0]=S0 holds an event, [1]=S1 holds an event
  logic       s0_pr_q, s0_ext_q;
  logic [7:0] s0_code_q;
  // S1 registered lookup
  logic       s1_pr_q, s1_map_q;
  logic [2:0] s1_row_q, s1_col_q;
  mod_e       s1_mod_q;
  // S2 state
  logic [7:0][7:0] matrix_q, matrix_d;
  logic lsh_q, rsh_q, ctl_l_q, ctl_r_q, alt_q, del_q;
  logic lsh_d, rsh_d, ctl_l_d, ctl_r_d, alt_d, del_d;
  logic kev_q, kev_d;
  // Reset request
  logic          combo_q;
  logic [CW-1:0] cnt_q;

  // Scan-code table lookup: {valid, row, col} plus modifier role.
  logic       lk_map;
  logic [2:0] lk_row, lk_col;
  mod_e       lk_mod;

  // Decode the latched S0 code into a matrix position.
  always_comb begin
    lk_map = 1'b0;
    lk_row = 3'd0;
    lk_col = 3'd0;
    lk_mod = M_NONE;
    unique case ({s0_ext_q, s0_code_q})
      9'h01C: begin lk_map = 1'b1; lk_row = 3'd2; lk_col = 3'd0; end // A
      9'h01B: begin lk_map = 1'b1; lk_row = 3'd2; lk_col = 3'd1; end // S
      9'h05A: begin lk_map = 1'b1; lk_row = 3'd1; lk_col = 3'd6; end // Enter
      9'h029: begin lk_map = 1'b1; lk_row = 3'd0; lk_col = 3'd4; end // Space
      9'h076: begin lk_map = 1'b1; lk_row = 3'd0; lk_col = 3'd0; end // Esc
      9'h012: begin lk_map = 1'b1; lk_row = 3'd0; lk_col = 3'd2; lk_mod = M_LSH;  end
      9'h059: begin lk_map = 1'b1; lk_row = 3'd0; lk_col = 3'd2; lk_mod = M_RSH;  end
      9'h014: begin lk_map = 1'b1; lk_row = 3'd0; lk_col = 3'd3; lk_mod = M_CTLL; end
      9'h114: begin lk_map = 1'b1; lk_row = 3'd0; lk_col = 3'd3; lk_mod = M_CTLR; end
      9'h175: begin lk_map = 1'b1; lk_row = 3'd7; lk_col = 3'd0; end // Up
      9'h172: begin lk_map = 1'b1; lk_row = 3'd7; lk_col = 3'd1; end // Down
      9'h16B: begin lk_map = 1'b1; lk_row = 3'd7; lk_col = 3'd2; end // Left
      9'h174: begin lk_map = 1'b1; lk_row = 3'd7; lk_col = 3'd3; end // Right
      9'h011, 9'h111: lk_mod = M_ALT;
      9'h171:         lk_mod = M_DEL;
      default: ;
    endcase
  end

  // S0 detect and S1 lookup registers; shadow takes the live strobe on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strobe_q   <= ps2_key[10];
      vld_pipe_q <= 2'b00;
      s0_pr_q    <= 1'b0;
      s0_ext_q   <= 1'b0;
      s0_code_q  <= 8'h00;
      s1_pr_q    <= 1'b0;
      s1_map_q   <= 1'b0;
      s1_row_q   <= 3'd0;
      s1_col_q   <= 3'd0;
      s1_mod_q   <= M_NONE;
    end else begin
      strobe_q      <= ps2_key[10];
      vld_pipe_q[0] <= ps2_key[10] != strobe_q;
      vld_pipe_q[1] <= vld_pipe_q[0];
      if (ps2_key[10] != strobe_q) begin
        s0_pr_q   <= ps2_key[9];
        s0_ext_q  <= ps2_key[8];
        s0_code_q <= ps2_key[7:0];
      end
      s1_pr_q  <= s0_pr_q;
      s1_map_q <= lk_map;
      s1_row_q <= lk_row;
      s1_col_q <= lk_col;
      s1_mod_q <= lk_mod;
    end
  end

  // S2 next state: modifier flops, matrix bit and change pulse.
  always_comb begin
    logic bit_new;
    matrix_d = matrix_q;
    lsh_d    = lsh_q;
    rsh_d    = rsh_q;
    ctl_l_d  = ctl_l_q;
    ctl_r_d  = ctl_r_q;
    alt_d    = alt_q;
    del_d    = del_q;
    kev_d    = 1'b0;
    bit_new  = s1_pr_q;
    if (vld_pipe_q[1]) begin
      unique case (s1_mod_q)
        M_LSH:   lsh_d   = s1_pr_q;
        M_RSH:   rsh_d   = s1_pr_q;
        M_CTLL:  ctl_l_d = s1_pr_q;
        M_CTLR:  ctl_r_d = s1_pr_q;
        M_ALT:   alt_d   = s1_pr_q;
        M_DEL:   del_d   = s1_pr_q;
        default: ;
      endcase
      if (s1_mod_q == M_LSH || s1_mod_q == M_RSH)   bit_new = lsh_d | rsh_d;
      if (s1_mod_q == M_CTLL || s1_mod_q == M_CTLR) bit_new = ctl_l_d | ctl_r_d;
      if (s1_map_q) begin
        matrix_d[s1_row_q][s1_col_q] = bit_new;
        kev_d = matrix_q[s1_row_q][s1_col_q] != bit_new;
      end
    end
  end

  // S2 state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      matrix_q <= '0;
      lsh_q    <= 1'b0;
      rsh_q    <= 1'b0;
      ctl_l_q  <= 1'b0;
      ctl_r_q  <= 1'b0;
      alt_q    <= 1'b0;
      del_q    <= 1'b0;
      kev_q    <= 1'b0;
    end else begin
      matrix_q <= matrix_d;
      lsh_q    <= lsh_d;
      rsh_q    <= rsh_d;
      ctl_l_q  <= ctl_l_d;
      ctl_r_q  <= ctl_r_d;
      alt_q    <= alt_d;
      del_q    <= del_d;
      kev_q    <= kev_d;
    end
  end

  // Reset-request hold counter, loaded only on the rising edge of the combo.
  logic combo;
  assign combo = (ctl_l_q | ctl_r_q) & alt_q & del_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      combo_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      combo_q <= combo;
      if (combo && !combo_q)   cnt_q <= CW'(RST_HOLD);
      else if (cnt_q != '0)    cnt_q <= cnt_q - CW'(1);
    end
  end

  // Column read: any selected row with the key down pulls its column low.
  always_comb begin
    col_n = 8'hFF;
    for (int r = 0; r < 8; r++)
      if (!row_sel_n[r]) col_n = col_n & ~matrix_q[r];
  end

  assign key_event = kev_q;
  assign rst_req   = cnt_q != '0;

endmodule

// File: tb/tb_osborne_kbd_matrix.sv
// Directed bench for osborne_kbd_matrix.
module tb_osborne_kbd_matrix;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [7:0]  row_sel_n;
  logic [7:0]  col_n;
  logic        key_event;
  logic        rst_req;

  int n_cmp = 0;
  int n_err = 0;
  int kev_cnt = 0;
  int hi;
  bit seen;

  osborne_kbd_matrix #(.RST_HOLD(16)) dut (
    .clk(clk), .reset(reset), .ps2_key(ps2_key), .row_sel_n(row_sel_n),
    .col_n(col_n), .key_event(key_event), .rst_req(rst_req)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (key_event) kev_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Toggle the strobe with a new event, right after an edge.
  task automatic post(input logic p, input logic e, input logic [7:0] code);
    ps2_key = {~ps2_key[10], p, e, code};
  endtask

  // Post an event and let it drain through the pipeline.
  task automatic send(input logic p, input logic e, input logic [7:0] code);
    post(p, e, code);
    tick(4);
  endtask

  // Wait for rst_req to rise, then count its high cycles.
  task automatic measure_req(output bit rose, output int cyc);
    rose = 0;
    cyc = 0;
    for (int i = 0; i < 30 && !rose; i++) begin
      if (rst_req) rose = 1;
      else tick(1);
    end
    while (rose && rst_req && cyc < 100) begin
      cyc++;
      tick(1);
    end
  endtask

  initial begin
    reset = 1'b1;
    ps2_key = 11'h400;
    row_sel_n = 8'hFB;
    tick(3);
    chk("rst_col", col_n, 8'hFF);
    chk("rst_kev", key_event, 1'b0);
    chk("rst_req0", rst_req, 1'b0);
    reset = 1'b0;
    tick(4);
    chk("rst_exit_nokev", kev_cnt, 0);

    // Test 1: press A, exact latency.
    tick(1);
    post(1'b1, 1'b0, 8'h1C);
    tick(1);                       // edge N: detect
    chk("t1_n", col_n, 8'hFF);
    tick(1);                       // edge N+1: lookup
    chk("t1_n1", col_n, 8'hFF);
    chk("t1_n1_kev", key_event, 1'b0);
    tick(1);                       // edge N+2: update
    chk("t1_n2", col_n, 8'hFE);
    chk("t1_n2_kev", key_event, 1'b1);
    tick(1);
    chk("t1_kev_1cyc", key_event, 1'b0);
    tick(2);
    chk("t1_kevcnt", kev_cnt, 1);

    // Test 2: release A.
    send(1'b0, 1'b0, 8'h1C);
    chk("t2_col", col_n, 8'hFF);
    chk("t2_kevcnt", kev_cnt, 2);

    // Test 3: both shifts share r0c2.
    row_sel_n = 8'hFE;
    send(1'b1, 1'b0, 8'h12);
    send(1'b1, 1'b0, 8'h59);
    chk("t3_both", col_n, 8'hFB);
    send(1'b0, 1'b0, 8'h12);
    chk("t3_rsh_held", col_n, 8'hFB);
    chk("t3_kev_mid", kev_cnt, 3);
    send(1'b0, 1'b0, 8'h59);
    chk("t3_none", col_n, 8'hFF);
    chk("t3_kevcnt", kev_cnt, 4);

    // Test 4: E0 Up plus Space, two rows selected.
    send(1'b1, 1'b1, 8'h75);
    send(1'b1, 1'b0, 8'h29);
    row_sel_n = 8'h7E;
    #1 chk("t4_or", col_n, 8'hEE);
    row_sel_n = 8'h7F;
    #1 chk("t4_row7", col_n, 8'hFE);
    row_sel_n = 8'hFF;
    #1 chk("t4_nosel", col_n, 8'hFF);
    chk("t4_kevcnt", kev_cnt, 6);

    // Test 5: unmapped, unknown E0, typematic repeat.
    row_sel_n = 8'h7E;
    send(1'b1, 1'b0, 8'h05);
    chk("t5_unmapped", col_n, 8'hEE);
    chk("t5_unm_kev", kev_cnt, 6);
    send(1'b1, 1'b0, 8'h1C);
    chk("t5_a_kev", kev_cnt, 7);
    send(1'b1, 1'b0, 8'h1C);
    chk("t5_repeat_kev", kev_cnt, 7);
    send(1'b0, 1'b1, 8'h1C);        // E0 1C is not A
    row_sel_n = 8'hFB;
    #1 chk("t5_e0_ignored", col_n, 8'hFE);
    chk("t5_e0_kev", kev_cnt, 7);

    // Back-to-back events on consecutive cycles: release Up, Space, A.
    post(1'b0, 1'b1, 8'h75);
    tick(1);
    post(1'b0, 1'b0, 8'h29);
    tick(1);
    post(1'b0, 1'b0, 8'h1C);
    tick(5);
    row_sel_n = 8'h00;
    #1 chk("b2b_all_rel", col_n, 8'hFF);
    chk("b2b_kevcnt", kev_cnt, 10);

    // Test 6: Ctrl+Alt+Del reset request.
    row_sel_n = 8'hFE;
    send(1'b1, 1'b0, 8'h14);
    chk("t6_ctrl_bit", col_n, 8'hF7);
    send(1'b1, 1'b0, 8'h11);
    post(1'b1, 1'b1, 8'h71);
    tick(1);
    measure_req(seen, hi);
    chk("t6_rose", seen, 1'b1);
    chk("t6_hold", hi, 16);
    chk("t6_low", rst_req, 1'b0);
    chk("t6_matrix_kept", col_n, 8'hF7);
    tick(20);
    chk("t6_no_retrig", rst_req, 1'b0);
    // Swap to right Ctrl while combo held: still no retrigger.
    send(1'b1, 1'b1, 8'h14);
    send(1'b0, 1'b0, 8'h14);
    chk("t6_rctrl_bit", col_n, 8'hF7);
    chk("t6_swap_noretrig", rst_req, 1'b0);
    send(1'b0, 1'b1, 8'h71);
    chk("t6_rel_low", rst_req, 1'b0);
    post(1'b1, 1'b1, 8'h71);
    tick(1);
    measure_req(seen, hi);
    chk("t6_rearm_rose", seen, 1'b1);
    chk("t6_rearm_hold", hi, 16);

    // Reset mid-event drops the in-flight event.
    post(1'b1, 1'b0, 8'h76);
    tick(1);
    reset = 1'b1;
    tick(1);
    chk("mid_rst_col", col_n, 8'hFF);
    reset = 1'b0;
    tick(5);
    chk("mid_rst_dropped", col_n, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
